// File: rtl/spi_rdid_shifter_if.sv
// Bus bundle between the SPI shift engine and its environment (request side plus SPI pins).
// id_match exists only when SPI_ID_CHECK_EN is defined.
interface spi_rdid_shifter_if;
   logic        start;
   logic [7:0]  tx_cmd;
   logic        busy;
   logic        done;
   logic [23:0] rx_data;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic        cs_n;
`ifdef SPI_ID_CHECK_EN
   logic        id_match;
`endif

   // master: upstream FSM plus the flash device; slave: the shift engine
   modport master (
      output start, tx_cmd, miso,
      input  busy, done, rx_data, sck, mosi, cs_n
`ifdef SPI_ID_CHECK_EN
      , input id_match
`endif
   );

   modport slave (
      input  start, tx_cmd, miso,
      output busy, done, rx_data, sck, mosi, cs_n
`ifdef SPI_ID_CHECK_EN
      , output id_match
`endif
   );
endinterface

// File: rtl/spi_rdid_shifter.sv
// SPI mode-0 engine: sends an 8-bit command, reads a 24-bit response, pulses done.
// Optional JEDEC ID compare output enabled by defining SPI_ID_CHECK_EN.
module spi_rdid_shifter #(
   parameter int unsigned CLK_DIV = 4
`ifdef SPI_ID_CHECK_EN
   , parameter logic [23:0] EXPECTED_ID = 24'h20BA18
`endif
) (
   input logic               clk,
   input logic               reset,
   spi_rdid_shifter_if.slave bus
);

   localparam int unsigned CntW = $clog2(CLK_DIV + 1);

   typedef enum logic [2:0] {StIdle, StSetup, StTx, StRx, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   div_q, div_d;
   logic [5:0]        bit_q, bit_d;
   logic              phase_q, phase_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [23:0]       shift_q, shift_d;
   logic [23:0]       rx_q, rx_d;
   logic              done_q, done_d;
   logic              last_half;
   logic              sck_o, mosi_o, cs_n_o, busy_o;
`ifdef SPI_ID_CHECK_EN
   logic              id_q, id_d;
`endif

   assign last_half = (div_q == CntW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         cmd_q   <= '0;
         shift_q <= '0;
         rx_q    <= '0;
         done_q  <= 1'b0;
`ifdef SPI_ID_CHECK_EN
         id_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         cmd_q   <= cmd_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         done_q  <= done_d;
`ifdef SPI_ID_CHECK_EN
         id_q    <= id_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      cmd_d   = cmd_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      done_d  = 1'b0;
`ifdef SPI_ID_CHECK_EN
      id_d    = id_q;
`endif
      if (state_q != StIdle) begin
         div_d = last_half ? '0 : div_q + CntW'(1);
      end
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StSetup;
               cmd_d   = bus.tx_cmd;
               div_d   = '0;
               bit_d   = '0;
               phase_d = 1'b0;
               shift_d = '0;
            end
         end
         StSetup: begin
            if (last_half) state_d = StTx;
         end
         StTx, StRx: begin
            if (last_half) begin
               phase_d = ~phase_q;
               // the edge that raises sck is the one that samples miso
               if (!phase_q) begin
                  if (state_q == StRx) shift_d = {shift_q[22:0], bus.miso};
               end else begin
                  bit_d = bit_q + 6'd1;
                  if (state_q == StTx) cmd_d = {cmd_q[6:0], 1'b0};
                  if (bit_q == 6'd7) state_d = StRx;
                  else if (bit_q == 6'd31) state_d = StHold;
               end
            end
         end
         StHold: begin
            if (last_half) begin
               state_d = StIdle;
               done_d  = 1'b1;
               rx_d    = shift_q;
`ifdef SPI_ID_CHECK_EN
               id_d    = (shift_q == EXPECTED_ID);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sck_o  = phase_q && ((state_q == StTx) || (state_q == StRx));
      mosi_o = ((state_q == StSetup) || (state_q == StTx)) ? cmd_q[7] : 1'b0;
      cs_n_o = (state_q == StIdle);
      busy_o = (state_q != StIdle);
   end

   assign bus.sck     = sck_o;
   assign bus.mosi    = mosi_o;
   assign bus.cs_n    = cs_n_o;
   assign bus.busy    = busy_o;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_q;
`ifdef SPI_ID_CHECK_EN
   assign bus.id_match = id_q;
`endif

endmodule

// File: tb/tb_spi_rdid_shifter.sv
// Bench for spi_rdid_shifter: table of transfers against a mode-0 flash model (CLK_DIV=2),
// plus reset-abort and back-to-back (CLK_DIV=1) sequences.
module tb_spi_rdid_shifter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_rdid_shifter_if b2 ();
   spi_rdid_shifter_if b1 ();

   spi_rdid_shifter #(.CLK_DIV(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
   spi_rdid_shifter #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Flash model for b2: mode 0, shifts response out after each falling sck
   logic [23:0] resp2 = '0;
   logic [7:0]  cmd_seen2 = '0;
   int          rises2 = 0, mosi_bad2 = 0, done_cnt2 = 0;
   logic        prev_sck2 = 1'b0, prev_cs2 = 1'b1;

   always @(negedge clk) begin
      if (b2.done) done_cnt2++;
      if (b2.cs_n) begin
         b2.miso = 1'b0;
      end else begin
         if (prev_cs2) begin
            rises2 = 0;
            cmd_seen2 = '0;
            mosi_bad2 = 0;
         end
         if (b2.sck && !prev_sck2) begin
            if (rises2 < 8) cmd_seen2 = {cmd_seen2[6:0], b2.mosi};
            else if (b2.mosi) mosi_bad2++;
            rises2++;
         end
         if (!b2.sck && prev_sck2 && rises2 >= 8 && rises2 < 32) b2.miso = resp2[31-rises2];
      end
      prev_sck2 = b2.sck;
      prev_cs2 = b2.cs_n;
   end

   // Monitor for b1 (miso tied high): done period and cs_n high gap
   int cyc1 = 0, last_done1 = -1, cs_run1 = 0;
   int periods1 = 0, per_bad1 = 0, gaps1 = 0, gap_bad1 = 0, rx_bad1 = 0;

   always @(negedge clk) begin
      cyc1++;
      if (b1.done) begin
         if (last_done1 >= 0) begin
            periods1++;
            if (cyc1 - last_done1 != 67) per_bad1++;
         end
         last_done1 = cyc1;
         if (b1.rx_data !== 24'hFFFFFF) rx_bad1++;
      end
      if (b1.cs_n) begin
         cs_run1++;
      end else begin
         if (cs_run1 > 0 && last_done1 >= 0) begin
            gaps1++;
            if (cs_run1 != 1) gap_bad1++;
         end
         cs_run1 = 0;
      end
   end

   task automatic xfer2(input logic [7:0] cmd, input logic [23:0] resp, input bit mid_start,
                        output int lat);
      resp2 = resp;
      @(posedge clk); #1;
      b2.start = 1'b1;
      b2.tx_cmd = cmd;
      @(posedge clk); #1;
      b2.start = 1'b0;
      b2.tx_cmd = 8'h00;
      chk("busy_after_accept", b2.busy, 1);
      chk("cs_n_after_accept", b2.cs_n, 0);
      lat = 0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         lat++;
         if (mid_start && lat == 40) begin
            b2.start = 1'b1;
            b2.tx_cmd = 8'h05;
         end
         if (mid_start && lat == 46) begin
            b2.start = 1'b0;
            b2.tx_cmd = 8'h00;
         end
         if (b2.done) break;
      end
      b2.start = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] resp;
      logic [23:0] exp_rx;
      logic [7:0]  exp_cmd;
      logic        exp_id;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int lat, dbase;
      vecs[0] = '{8'h9F, 24'h20BA18, 24'h20BA18, 8'h9F, 1'b1};
      vecs[1] = '{8'h9F, 24'h000000, 24'h000000, 8'h9F, 1'b0};
      vecs[2] = '{8'hA5, 24'hFFFFFF, 24'hFFFFFF, 8'hA5, 1'b0};
      vecs[3] = '{8'h3C, 24'h800001, 24'h800001, 8'h3C, 1'b0};
      vecs[4] = '{8'h01, 24'h5A0FC3, 24'h5A0FC3, 8'h01, 1'b0};

      reset = 1'b0;
      b2.start = 1'b0;
      b2.tx_cmd = 8'h00;
      b1.start = 1'b0;
      b1.tx_cmd = 8'h00;
      b1.miso = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", b2.cs_n, 1);
      chk("rst_sck", b2.sck, 0);
      chk("rst_mosi", b2.mosi, 0);
      chk("rst_busy", b2.busy, 0);
      chk("rst_done", b2.done, 0);
      chk("rst_rx_data", b2.rx_data, 24'h0);
      chk("rst_cs_n_div1", b1.cs_n, 1);
`ifdef SPI_ID_CHECK_EN
      chk("rst_id_match", b2.id_match, 0);
`endif
      reset = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 5; i++) begin
         dbase = done_cnt2;
         xfer2(vecs[i].cmd, vecs[i].resp, 1'b0, lat);
         chk("latency", lat, 132);
         chk("rx_data", b2.rx_data, vecs[i].exp_rx);
         chk("cmd_seen", cmd_seen2, vecs[i].exp_cmd);
         chk("sck_rises", rises2, 32);
         chk("mosi_low_in_rx", mosi_bad2, 0);
         chk("busy_at_done", b2.busy, 0);
         chk("cs_n_at_done", b2.cs_n, 1);
`ifdef SPI_ID_CHECK_EN
         chk("id_match", b2.id_match, vecs[i].exp_id);
`endif
         @(posedge clk); #1;
         chk("done_one_cycle", b2.done, 0);
         chk("done_count", done_cnt2 - dbase, 1);
         chk("rx_data_held", b2.rx_data, vecs[i].exp_rx);
      end

      // start pulsed mid-transfer with a different command must be ignored
      dbase = done_cnt2;
      xfer2(8'h9F, 24'h20BA18, 1'b1, lat);
      chk("mid_latency", lat, 132);
      chk("mid_cmd_seen", cmd_seen2, 8'h9F);
      chk("mid_rx_data", b2.rx_data, 24'h20BA18);
      repeat (300) @(posedge clk);
      #1;
      chk("mid_single_done", done_cnt2 - dbase, 1);
      chk("mid_idle", b2.busy, 0);

      // reset asserted at the 20th sck rise aborts the transfer
      resp2 = 24'h123456;
      @(posedge clk); #1;
      b2.start = 1'b1;
      b2.tx_cmd = 8'h9F;
      @(posedge clk); #1;
      b2.start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if (rises2 >= 20) break;
      end
      chk("abort_reached_rise20", rises2, 20);
      dbase = done_cnt2;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("abort_cs_n", b2.cs_n, 1);
      chk("abort_sck", b2.sck, 0);
      chk("abort_busy", b2.busy, 0);
      chk("abort_done", b2.done, 0);
      reset = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt2 - dbase, 0);
      chk("abort_rx_cleared", b2.rx_data, 24'h0);
      xfer2(8'h9F, 24'hC3A55A, 1'b0, lat);
      chk("after_abort_latency", lat, 132);
      chk("after_abort_rx", b2.rx_data, 24'hC3A55A);
      chk("after_abort_cmd", cmd_seen2, 8'h9F);

      // back-to-back transfers with start held high, CLK_DIV=1
      @(posedge clk); #1;
      b1.start = 1'b1;
      b1.tx_cmd = 8'h9F;
      repeat (211) @(posedge clk);
      #1;
      b1.start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("b2b_periods_seen", periods1 >= 3, 1);
      chk("b2b_period_67", per_bad1, 0);
      chk("b2b_gaps_seen", gaps1 >= 3, 1);
      chk("b2b_cs_gap_1", gap_bad1, 0);
      chk("b2b_rx_data", rx_bad1, 0);
      chk("b2b_idle", b1.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
